// File: rtl/rr_grant_if.sv
// Request/grant bundle between the requesters and the round-robin grant sequencer.
interface rr_grant_if #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
);
    logic             arb_en;
    logic [N_REQ-1:0] req;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant_onehot;
    logic             preempt;

    // master: requester side; slave: the arbiter
    modport master (
        output arb_en, req,
        input  grant_valid, grant_idx, grant_onehot, preempt
    );

    modport slave (
        input  arb_en, req,
        output grant_valid, grant_idx, grant_onehot, preempt
    );
endinterface

// File: rtl/rr_grant_sequencer.sv
// Round-robin sequencer for one shared bus: bounded tenure, one dead cycle between owners.
//   state | meaning
//   IDLE  | bus free, arbitrate when arb_en and any request
//   GRANT | grant_idx owns the bus, tenure counted in hold_cnt
//   GAP   | single dead cycle after an owner leaves, then arbitrate
module rr_grant_sequencer #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_grant_if.slave   bus
);
    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [IDX_W-1:0]  last_idx, last_idx_nxt;
    logic              grant_valid_nxt;
    logic [IDX_W-1:0]  grant_idx_nxt;
    logic [N_REQ-1:0]  grant_onehot_nxt;
    logic              preempt_nxt;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic              rel_cond;
    logic              oth_pend;

    // last_idx itself is scanned last, so a previous owner only wins when alone
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!win_found && bus.req[last_idx + IDX_W'(k)]) begin
                win_found = 1'b1;
                win_idx   = last_idx + IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        hold_cnt_nxt     = hold_cnt;
        last_idx_nxt     = last_idx;
        grant_valid_nxt  = bus.grant_valid;
        grant_idx_nxt    = bus.grant_idx;
        grant_onehot_nxt = bus.grant_onehot;
        preempt_nxt      = 1'b0;
        rel_cond         = !bus.req[bus.grant_idx];
        oth_pend         = |(bus.req & ~bus.grant_onehot);

        case (state)
            IDLE, GAP: begin
                state_nxt        = IDLE;
                grant_valid_nxt  = 1'b0;
                grant_onehot_nxt = '0;
                hold_cnt_nxt     = '0;
                if (bus.arb_en && win_found) begin
                    state_nxt        = GRANT;
                    grant_valid_nxt  = 1'b1;
                    grant_idx_nxt    = win_idx;
                    grant_onehot_nxt = N_REQ'(1) << win_idx;
                end
            end
            GRANT: begin
                if (rel_cond || (hold_cnt == HOLD_SAT && oth_pend)) begin
                    state_nxt        = GAP;
                    grant_valid_nxt  = 1'b0;
                    grant_onehot_nxt = '0;
                    last_idx_nxt     = bus.grant_idx;
                    hold_cnt_nxt     = '0;
                    preempt_nxt      = !rel_cond;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            hold_cnt         <= '0;
            last_idx         <= IDX_W'(N_REQ - 1);
            bus.grant_valid  <= 1'b0;
            bus.grant_idx    <= '0;
            bus.grant_onehot <= '0;
            bus.preempt      <= 1'b0;
        end else begin
            state            <= state_nxt;
            hold_cnt         <= hold_cnt_nxt;
            last_idx         <= last_idx_nxt;
            bus.grant_valid  <= grant_valid_nxt;
            bus.grant_idx    <= grant_idx_nxt;
            bus.grant_onehot <= grant_onehot_nxt;
            bus.preempt      <= preempt_nxt;
        end
    end
endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed and randomized bench for rr_grant_sequencer against a cycle-level ownership model.
module tb_rr_grant_sequencer;
    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    rr_grant_if bus ();

    rr_grant_sequencer #(.N_REQ(8), .IDX_W(3), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: who owns the bus and for how many cycles so far
    int         m_owner;
    int         m_tenure;
    int         m_last;
    logic [2:0] m_idx;
    bit         m_pre;

    function automatic void model_reset();
        m_owner  = -1;
        m_tenure = 0;
        m_last   = 7;
        m_idx    = 3'd0;
        m_pre    = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] r, input logic en);
        m_pre = 1'b0;
        if (m_owner >= 0) begin
            bit rel, oth;
            rel = !r[m_owner];
            oth = (r & ~(8'd1 << m_owner)) != 8'd0;
            if (rel || (m_tenure >= MAX_HOLD && oth)) begin
                m_pre   = !rel;
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_tenure++;
            end
        end else if (en && r != 8'd0) begin
            for (int k = 1; k <= 8; k++) begin
                int c;
                c = (m_last + k) % 8;
                if (r[c]) begin
                    m_owner = c;
                    break;
                end
            end
            m_idx    = 3'(m_owner);
            m_tenure = 1;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] exp_oh;
        exp_oh = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        chk({tag, ".valid"},   32'(bus.grant_valid),  32'(m_owner >= 0));
        chk({tag, ".idx"},     32'(bus.grant_idx),    32'(m_idx));
        chk({tag, ".onehot"},  32'(bus.grant_onehot), 32'(exp_oh));
        chk({tag, ".preempt"}, 32'(bus.preempt),      32'(m_pre));
    endtask

    task automatic tick(input logic [7:0] r, input logic en, input string tag);
        bus.req    = r;
        bus.arb_en = en;
        @(posedge clk);
        model_step(r, en);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        rst_n      = 1'b0;
        bus.req    = 8'h00;
        bus.arb_en = 1'b0;
        model_reset();
        #3;
        check_model("por");
        @(negedge clk);
        rst_n = 1'b1;

        // first grant after reset
        tick(8'h01, 1'b1, "t1");
        chk("t1.valid", 32'(bus.grant_valid), 32'd1);
        chk("t1.idx", 32'(bus.grant_idx), 32'd0);
        chk("t1.onehot", 32'(bus.grant_onehot), 32'h01);
        chk("t1.preempt", 32'(bus.preempt), 32'd0);
        tick(8'h00, 1'b1, "t1.rel");
        tick(8'h00, 1'b1, "t1.idle");

        // all requesting: 16-cycle tenures, preempt pulse in each gap cycle
        do_reset();
        for (int t = 1; t <= 9 * 17; t++) begin
            tick(8'hFF, 1'b1, "t2");
            chk("t2.valid", 32'(bus.grant_valid), 32'((t % 17) != 0));
            chk("t2.preempt", 32'(bus.preempt), 32'((t % 17) == 0));
            if ((t % 17) != 0)
                chk("t2.idx", 32'(bus.grant_idx), 32'(((t - 1) / 17) % 8));
        end

        // release before MAX_HOLD hands over after one gap, no preempt
        do_reset();
        tick(8'h08, 1'b1, "t3");
        chk("t3.idx3", 32'(bus.grant_idx), 32'd3);
        for (int i = 0; i < 3; i++) tick(8'h28, 1'b1, "t3");
        tick(8'h20, 1'b1, "t3.gap");
        chk("t3.gap.valid", 32'(bus.grant_valid), 32'd0);
        chk("t3.gap.preempt", 32'(bus.preempt), 32'd0);
        tick(8'h20, 1'b1, "t3.next");
        chk("t3.idx5", 32'(bus.grant_idx), 32'd5);
        chk("t3.valid5", 32'(bus.grant_valid), 32'd1);

        // sole requester keeps the bus past MAX_HOLD
        do_reset();
        for (int i = 0; i < 40; i++) begin
            tick(8'h40, 1'b1, "t4");
            chk("t4.valid", 32'(bus.grant_valid), 32'd1);
            chk("t4.idx", 32'(bus.grant_idx), 32'd6);
            chk("t4.preempt", 32'(bus.preempt), 32'd0);
        end

        // arb_en gating
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(8'h0C, 1'b0, "t5.frozen");
            chk("t5.frozen.valid", 32'(bus.grant_valid), 32'd0);
        end
        tick(8'h0C, 1'b1, "t5.go");
        chk("t5.go.idx", 32'(bus.grant_idx), 32'd2);
        chk("t5.go.valid", 32'(bus.grant_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick(8'h04, 1'b0, "t5.hold");
            chk("t5.hold.valid", 32'(bus.grant_valid), 32'd1);
        end
        tick(8'h00, 1'b0, "t5.rel");
        chk("t5.rel.valid", 32'(bus.grant_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick(8'h0C, 1'b0, "t5.idle");
            chk("t5.idle.valid", 32'(bus.grant_valid), 32'd0);
        end

        // async reset mid-grant loses rotation history
        do_reset();
        tick(8'h10, 1'b1, "t6");
        tick(8'h10, 1'b1, "t6");
        chk("t6.idx4", 32'(bus.grant_idx), 32'd4);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6.async.valid", 32'(bus.grant_valid), 32'd0);
        chk("t6.async.onehot", 32'(bus.grant_onehot), 32'd0);
        chk("t6.async.idx", 32'(bus.grant_idx), 32'd0);
        bus.req = 8'h11;
        @(negedge clk);
        rst_n = 1'b1;
        tick(8'h11, 1'b1, "t6.after");
        chk("t6.after.idx", 32'(bus.grant_idx), 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            if ($urandom_range(0, 399) == 0) do_reset();
            case (r[31:30])
                2'd0: tick(r[7:0], r[29:27] != 3'd0, "rnd");
                2'd1: tick(r[7:0] & r[15:8], r[29:27] != 3'd0, "rnd");
                2'd2: tick(r[7:0] | r[15:8], 1'b1, "rnd");
                default: tick(bus.req, r[29:27] != 3'd0, "rnd");
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
